cpu_mem_ctrl: RTL



---
 rtl/cpu_mem_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cpu_mem_ctrl.sv
// rtl/cpu_mem_ctrl.sv - RV32 core request port: register-slot/RAM, LED and cycle-counter bus controller
// One outstanding read at a time; writes complete on the strobe edge in any state.
module cpu_mem_ctrl #(
    parameter int    MEM_WORDS   = 4096,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en,
    input  logic [15:0] i_addr,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic [7:0]  led,
    output logic        bus_err
);
    localparam int          AW       = $clog2(MEM_WORDS);
    localparam logic [16:0] RAM_TOP  = 17'(4 * MEM_WORDS);
    localparam logic [15:0] LED_ADDR = 16'hFF00;
    localparam logic [15:0] CYC_ADDR = 16'hFF04;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {SRC_RAM, SRC_LED, SRC_CYC, SRC_ERR} src_t;

    function automatic src_t decode(input logic [15:0] a);
        if (a == LED_ADDR) return SRC_LED;
        if (a == CYC_ADDR) return SRC_CYC;
        if ({1'b0, a} < RAM_TOP) return SRC_RAM;
        return SRC_ERR;
    endfunction

    logic [31:0] mem [MEM_WORDS];

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [15:0] addr_q, addr_d;
    src_t        src_q, src_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  led_q, led_d;
    logic        err_q, err_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] ram_rd_q;

    logic [15:0]   word_addr;
    src_t          in_src;
    logic          misaligned;
    logic          wr_ram;
    logic          rd_accept;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign word_addr  = {i_addr[15:2], 2'b00};
    assign in_src     = decode(word_addr);
    assign misaligned = |i_addr[1:0];
    assign wr_ram     = wr_en && (in_src == SRC_RAM) && (word_addr != 16'h0000);
    // The rd_valid cycle still sees rd_en held by the core, so it must not start a new read.
    assign rd_accept  = (state_q == IDLE) && rd_en && !wr_en && !rd_valid_q;
    assign wr_idx     = word_addr[AW+1:2];
    assign rd_idx     = rd_accept ? wr_idx : addr_q[AW+1:2];

    // RAM is re-read at the pending address every cycle, so writes landing during WAIT are seen.
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            mem[wr_idx] <= wr_data;
        end
        ram_rd_q <= (wr_ram && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        addr_d     = addr_q;
        src_d      = src_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        led_d      = led_q;
        err_d      = err_q;
        cyc_d      = cyc_q + 32'd1;

        if (wr_en) begin
            if (in_src == SRC_LED) begin
                led_d = wr_data[7:0];
            end
            if (misaligned || (in_src == SRC_ERR)) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (rd_accept) begin
                    addr_d  = word_addr;
                    src_d   = in_src;
                    wait_d  = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? WAIT : RESP;
                    if (misaligned || (in_src == SRC_ERR)) begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (wait_q <= 4'd1) begin
                    state_d = RESP;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            RESP: begin
                rd_valid_d = 1'b1;
                state_d    = IDLE;
                case (src_q)
                    SRC_RAM: rd_data_d = (addr_q == 16'h0000) ? 32'h0000_0000 : ram_rd_q;
                    SRC_LED: rd_data_d = {24'h00_0000, led_q};
                    SRC_CYC: rd_data_d = cyc_q;
                    default: rd_data_d = 32'hDEAD_BEEF;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_q     <= 4'd0;
            addr_q     <= 16'h0000;
            src_q      <= SRC_RAM;
            rd_data_q  <= 32'h0000_0000;
            rd_valid_q <= 1'b0;
            led_q      <= 8'h00;
            err_q      <= 1'b0;
            cyc_q      <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            addr_q     <= addr_d;
            src_q      <= src_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            led_q      <= led_d;
            err_q      <= err_d;
            cyc_q      <= cyc_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign led      = led_q;
    assign bus_err  = err_q;
endmodule
